// File: rtl/fram_sync_ctrl_pkg.sv
// fram_sync_pkg
// Shared definitions for the frame-synchronisation controller and any other
// frame-head consumers. It holds the state encoding, the frame counter width,
// the error counter width and its saturation value, and a saturating
// increment helper.
package fram_sync_pkg;

    localparam int CNT_W = 26;
    localparam int ERR_W = 8;

    localparam logic [ERR_W-1:0] ERR_SAT = 8'd255;

    // Kept as plain 2-bit constants so legacy code comparing raw o_state
    // values keeps working.
    localparam logic [1:0] ST_SEARCH = 2'b00;
    localparam logic [1:0] ST_VERIFY = 2'b01;
    localparam logic [1:0] ST_LOCK   = 2'b10;

    function automatic logic [ERR_W-1:0] sat_inc(input logic [ERR_W-1:0] value);
        return (value == ERR_SAT) ? value : value + 1'b1;
    endfunction

endpackage

// File: rtl/fram_sync_ctrl_if.sv
// fram_sync_ctrl_if
// Bundles the frame-head input, the resync request and the regenerated frame
// outputs of fram_sync_ctrl.
//   i_fram_hd  : raw external frame head (asynchronous level)
//   i_resync   : one-cycle request to drop back to SEARCH
//   o_fram_hd  : regenerated head, high for the cycle where o_fram_cnt == 0
//   o_fram_cnt : frame position 0..FRAM_MAX
//   o_state    : 00 SEARCH, 01 VERIFY, 10 LOCK
//   o_lock     : high while in LOCK
//   o_err_cnt  : saturating count of off-window heads seen in LOCK
// The master modport is the side that drives the head/resync inputs and
// consumes the frame outputs; the slave modport is the controller.
interface fram_sync_ctrl_if;
    import fram_sync_pkg::*;

    logic             i_fram_hd;
    logic             i_resync;
    logic             o_fram_hd;
    logic [CNT_W-1:0] o_fram_cnt;
    logic [1:0]       o_state;
    logic             o_lock;
    logic [ERR_W-1:0] o_err_cnt;

    modport master (
        output i_fram_hd,
        output i_resync,
        input  o_fram_hd,
        input  o_fram_cnt,
        input  o_state,
        input  o_lock,
        input  o_err_cnt
    );

    modport slave (
        input  i_fram_hd,
        input  i_resync,
        output o_fram_hd,
        output o_fram_cnt,
        output o_state,
        output o_lock,
        output o_err_cnt
    );

endinterface

// File: rtl/fram_sync_ctrl_edge.sv
// fram_edge_sync
// Conditions an asynchronous frame-head level into a single-cycle pulse.
//   clk     : clock
//   rst     : asynchronous active-high reset
//   fram_hd : raw frame head input
//   hd_p    : registered one-cycle pulse on each conditioned rising edge
// The first two shift stages act as the synchroniser. A rising edge is taken
// at shift[3:2] == 01, so a head first sampled at edge k pulses in the cycle
// after edge k+3.
module fram_edge_sync (
    input  logic clk,
    input  logic rst,
    input  logic fram_hd,
    output logic hd_p
);

    logic [3:0] shift;
    logic       prev_high;

    // prev_high is the sample that left shift[3]. Requiring it low as well
    // means a rise must follow at least two low samples, so a head with a
    // single-sample dropout is merged into one pulse.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            shift     <= '0;
            prev_high <= 1'b0;
            hd_p      <= 1'b0;
        end else begin
            shift     <= {shift[2:0], fram_hd};
            prev_high <= shift[3];
            hd_p      <= (shift[3:2] == 2'b01) && !prev_high;
        end
    end

endmodule

// File: rtl/fram_sync_ctrl.sv
// fram_sync_ctrl
// Frame-synchronisation controller. It runs a flywheel frame counter of
// period FRAM_MAX+1, classifies each conditioned head against an acceptance
// window around the frame boundary, and sequences SEARCH/VERIFY/LOCK to
// decide when the counter realigns to the external head.
//   clk : clock
//   rst : asynchronous active-high reset
//   bus : fram_sync_ctrl_if slave (head/resync in, frame position/status out)
// Parameters: FRAM_MAX (last count), WIN (half-window), LOCK_CNT (good heads
// to lock), UNLOCK_CNT (missed windows to drop lock).
module fram_sync_ctrl
    import fram_sync_pkg::*;
#(
    parameter logic [CNT_W-1:0] FRAM_MAX   = 26'd4915199,
    parameter logic [7:0]       WIN        = 8'd2,
    parameter logic [3:0]       LOCK_CNT   = 4'd3,
    parameter logic [3:0]       UNLOCK_CNT = 4'd4
) (
    input logic             clk,
    input logic             rst,
    fram_sync_ctrl_if.slave bus
);

    localparam logic [CNT_W-1:0] WIN_EXT  = CNT_W'(WIN);
    localparam logic [CNT_W-1:0] OPEN_AT  = FRAM_MAX - WIN_EXT;
    localparam logic [CNT_W-1:0] CLOSE_AT = WIN_EXT - CNT_W'(1);

    logic             hd_p;
    logic             hd;
    logic             on_time;
    logic             miss_evt;
    logic             realign;

    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cnt_nx;
    logic             fram_hd;
    logic [1:0]       state;
    logic [1:0]       state_nx;
    logic [3:0]       good;
    logic [3:0]       good_nx;
    logic [3:0]       good_inc;
    logic [3:0]       miss;
    logic [3:0]       miss_nx;
    logic [3:0]       miss_inc;
    logic [ERR_W-1:0] err_cnt;
    logic [ERR_W-1:0] err_nx;
    logic             win_hit;
    logic             win_hit_nx;

    fram_edge_sync u_edge (
        .clk     (clk),
        .rst     (rst),
        .fram_hd (bus.i_fram_hd),
        .hd_p    (hd_p)
    );

    // A head coinciding with a resync request is discarded.
    assign hd       = hd_p && !bus.i_resync;
    assign on_time  = hd && ((cnt >= OPEN_AT) || (cnt <= CLOSE_AT));
    assign miss_evt = (cnt == CLOSE_AT) && !win_hit && !on_time;
    assign realign  = hd && (state != ST_LOCK);
    assign good_inc = good + 4'd1;
    assign miss_inc = miss + 4'd1;

    // Counter and window bookkeeping. A realigning head sits at position
    // FRAM_MAX of the new frame, so it also satisfies the window that is
    // about to close; otherwise an off-window realign would immediately
    // register a miss. The hit flag is cleared only when a window opens so
    // that a realign late in a window does not re-arm it.
    always_comb begin
        cnt_nx = (cnt == FRAM_MAX) ? '0 : cnt + CNT_W'(1);
        if (realign) begin
            cnt_nx = '0;
        end
        win_hit_nx = win_hit;
        if (realign || on_time) begin
            win_hit_nx = 1'b1;
        end else if (cnt == OPEN_AT) begin
            win_hit_nx = 1'b0;
        end
    end

    // SEARCH/VERIFY/LOCK sequencing; resync overrides every other event.
    always_comb begin
        state_nx = state;
        good_nx  = good;
        miss_nx  = miss;
        err_nx   = err_cnt;
        if (bus.i_resync) begin
            state_nx = ST_SEARCH;
            good_nx  = '0;
            miss_nx  = '0;
        end else begin
            case (state)
                ST_SEARCH: begin
                    if (hd) begin
                        state_nx = ST_VERIFY;
                        good_nx  = 4'd1;
                    end
                end
                ST_VERIFY: begin
                    if (on_time) begin
                        good_nx = good_inc;
                        if (good_inc >= LOCK_CNT) begin
                            state_nx = ST_LOCK;
                            miss_nx  = '0;
                        end
                    end else if (hd) begin
                        good_nx = 4'd1;
                    end else if (miss_evt) begin
                        state_nx = ST_SEARCH;
                        good_nx  = '0;
                    end
                end
                ST_LOCK: begin
                    if (on_time) begin
                        miss_nx = '0;
                    end else if (hd) begin
                        err_nx = sat_inc(err_cnt);
                    end
                    if (miss_evt) begin
                        miss_nx = miss_inc;
                        if (miss_inc >= UNLOCK_CNT) begin
                            state_nx = ST_SEARCH;
                            miss_nx  = '0;
                            good_nx  = '0;
                        end
                    end
                end
                default: begin
                    state_nx = ST_SEARCH;
                    good_nx  = '0;
                    miss_nx  = '0;
                end
            endcase
        end
    end

    // o_fram_hd is registered from the next count so it lines up with
    // cnt == 0; it stays low out of reset because no frame has ended yet.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt     <= '0;
            fram_hd <= 1'b0;
            state   <= ST_SEARCH;
            good    <= '0;
            miss    <= '0;
            err_cnt <= '0;
            win_hit <= 1'b0;
        end else begin
            cnt     <= cnt_nx;
            fram_hd <= (cnt_nx == '0);
            state   <= state_nx;
            good    <= good_nx;
            miss    <= miss_nx;
            err_cnt <= err_nx;
            win_hit <= win_hit_nx;
        end
    end

    assign bus.o_fram_cnt = cnt;
    assign bus.o_fram_hd  = fram_hd;
    assign bus.o_state    = state;
    assign bus.o_lock     = (state == ST_LOCK);
    assign bus.o_err_cnt  = err_cnt;

endmodule

// File: tb/tb_fram_sync_ctrl.sv
// tb_fram_sync_ctrl
// Self-checking bench for fram_sync_ctrl with FRAM_MAX = 99, WIN = 2,
// LOCK_CNT = 3, UNLOCK_CNT = 4. A behavioural model built from frame-level
// rules predicts every output each cycle; directed scenarios add fixed
// expectations, followed by a randomized head stream.
module tb_fram_sync_ctrl;

    localparam int P       = 100;
    localparam int W       = 2;
    localparam int LOCKN   = 3;
    localparam int UNLOCKN = 4;

    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    fram_sync_ctrl_if bus ();

    fram_sync_ctrl #(
        .FRAM_MAX   (26'd99),
        .WIN        (8'd2),
        .LOCK_CNT   (4'd3),
        .UNLOCK_CNT (4'd4)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int errors = 0;
    int checks = 0;

    // Reference model: raw sample history plus frame-level status.
    int samp [7];
    int m_cnt, m_state, m_good, m_miss, m_err, m_hit, m_fhd;

    task automatic checkOutput(input string tag, input logic [63:0] actual,
                               input logic [63:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0h, expected %0h", tag, actual, expected);
        end
    endtask

    function automatic logic [63:0] actVec();
        return {26'd0, bus.o_fram_hd, bus.o_lock, bus.o_state, bus.o_err_cnt, bus.o_fram_cnt};
    endfunction

    function automatic logic [63:0] expVec();
        return {26'd0, 1'(m_fhd), 1'(m_state == 2), 2'(m_state), 8'(m_err), 26'(m_cnt)};
    endfunction

    task automatic modelReset();
        for (int i = 0; i < 7; i++) samp[i] = 0;
        m_cnt = 0; m_state = 0; m_good = 0; m_miss = 0;
        m_err = 0; m_hit = 0; m_fhd = 0;
    endtask

    // One clock edge of the model. A head is a sample that rose after two low
    // samples, seen by the frame logic four edges after it was sampled.
    // pos is the distance into the acceptance window (0 = window opens).
    task automatic modelStep(input bit hd_in, input bit rs);
        int pos, n_cnt, n_state, n_good, n_miss, n_err, n_hit;
        bit h, on, missed, realign;
        for (int i = 6; i > 0; i--) samp[i] = samp[i-1];
        samp[0] = int'(hd_in);
        h       = (samp[4] == 1) && (samp[5] == 0) && (samp[6] == 0) && !rs;
        pos     = (m_cnt + W + 1) % P;
        on      = h && (pos < 2*W + 1);
        missed  = (pos == 2*W) && (m_hit == 0) && !on;
        realign = h && (m_state != 2);
        n_cnt   = realign ? 0 : (m_cnt + 1) % P;
        n_hit   = (realign || on) ? 1 : ((pos == 0) ? 0 : m_hit);
        n_state = m_state; n_good = m_good; n_miss = m_miss; n_err = m_err;
        if (rs) begin
            n_state = 0; n_good = 0; n_miss = 0;
        end else if (m_state == 0) begin
            if (h) begin n_state = 1; n_good = 1; end
        end else if (m_state == 1) begin
            if (on) begin
                n_good = m_good + 1;
                if (n_good >= LOCKN) begin n_state = 2; n_miss = 0; end
            end else if (h) begin
                n_good = 1;
            end else if (missed) begin
                n_state = 0; n_good = 0;
            end
        end else begin
            if (on) n_miss = 0;
            else if (h) n_err = (m_err < 255) ? m_err + 1 : 255;
            if (missed) begin
                n_miss = m_miss + 1;
                if (n_miss >= UNLOCKN) begin n_state = 0; n_miss = 0; n_good = 0; end
            end
        end
        m_cnt = n_cnt; m_state = n_state; m_good = n_good; m_miss = n_miss;
        m_err = n_err; m_hit = n_hit; m_fhd = (n_cnt == 0) ? 1 : 0;
    endtask

    // Drive one cycle from a negedge, advance the model at the posedge and
    // compare all outputs at the following negedge.
    task automatic applyStimulus(input bit hd, input bit rs);
        bus.i_fram_hd = hd;
        bus.i_resync  = rs;
        @(posedge clk);
        modelStep(hd, rs);
        @(negedge clk);
        checkOutput("outputs", actVec(), expVec());
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) applyStimulus(1'b0, 1'b0);
    endtask

    task automatic sendHead();
        applyStimulus(1'b1, 1'b0);
        applyStimulus(1'b1, 1'b0);
        applyStimulus(1'b0, 1'b0);
        applyStimulus(1'b0, 1'b0);
    endtask

    task automatic waitCnt(input int c);
        for (int i = 0; i < 2*P && m_cnt != c; i++) applyStimulus(1'b0, 1'b0);
    endtask

    // The head reaches the frame logic four edges after its first sample.
    task automatic headAt(input int target);
        waitCnt((target - 4 + P) % P);
        sendHead();
    endtask

    initial begin
        #1_000_000;
        $display("[TB] FAIL watchdog: got timeout, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int cyc;
        int cd;
        int pl;
        bit hd_b;
        bit rs_b;

        bus.i_fram_hd = 1'b0;
        bus.i_resync  = 1'b0;
        rst = 1'b1;
        modelReset();
        repeat (2) @(negedge clk);
        checkOutput("reset_cnt",   64'(bus.o_fram_cnt), 64'd0);
        checkOutput("reset_fhd",   64'(bus.o_fram_hd),  64'd0);
        checkOutput("reset_state", 64'(bus.o_state),    64'd0);
        checkOutput("reset_lock",  64'(bus.o_lock),     64'd0);
        checkOutput("reset_err",   64'(bus.o_err_cnt),  64'd0);
        rst = 1'b0;

        // Free run from reset: first regenerated head after FRAM_MAX+1 clocks.
        idle(99);
        checkOutput("freerun_cnt99", 64'(bus.o_fram_cnt), 64'd99);
        checkOutput("freerun_fhd0",  64'(bus.o_fram_hd),  64'd0);
        idle(1);
        checkOutput("freerun_wrap",  64'(bus.o_fram_cnt), 64'd0);
        checkOutput("freerun_fhd1",  64'(bus.o_fram_hd),  64'd1);

        // Lock acquire with heads exactly 100 clocks apart.
        $display("[TB] lock acquire");
        idle(30);
        for (int k = 0; k < 3; k++) begin
            sendHead();
            idle(4);
            checkOutput("acq_cnt", 64'(bus.o_fram_cnt), 64'd3);
            checkOutput("acq_lock", 64'(bus.o_lock), (k == 2) ? 64'd1 : 64'd0);
            if (k < 2) checkOutput("acq_state", 64'(bus.o_state), 64'd1);
            idle(92);
        end

        // Jitter inside the window does not move the phase.
        $display("[TB] jitter tolerance");
        headAt(97);
        idle(6);
        checkOutput("early_phase", 64'(bus.o_fram_cnt), 64'd3);
        headAt(1);
        idle(6);
        checkOutput("late_phase", 64'(bus.o_fram_cnt), 64'd7);
        headAt(96);
        idle(6);
        checkOutput("offwin_err",   64'(bus.o_err_cnt),  64'd1);
        checkOutput("offwin_phase", 64'(bus.o_fram_cnt), 64'd2);
        checkOutput("offwin_lock",  64'(bus.o_lock),     64'd1);

        // A one-sample dropout inside a head must give a single pulse.
        waitCnt(46);
        applyStimulus(1'b1, 1'b0);
        applyStimulus(1'b0, 1'b0);
        applyStimulus(1'b1, 1'b0);
        applyStimulus(1'b0, 1'b0);
        applyStimulus(1'b0, 1'b0);
        idle(6);
        checkOutput("merge_err", 64'(bus.o_err_cnt), 64'd2);

        // Loss of lock: heads stop after one last on-time head at cnt 99.
        $display("[TB] loss of lock");
        headAt(99);
        cyc = 0;
        while (m_state != 0 && cyc < 600) begin
            applyStimulus(1'b0, 1'b0);
            cyc++;
        end
        checkOutput("unlock_cycles", 64'(cyc), 64'd403);
        checkOutput("unlock_state",  64'(bus.o_state),    64'd0);
        checkOutput("unlock_lock",   64'(bus.o_lock),     64'd0);
        checkOutput("unlock_cnt",    64'(bus.o_fram_cnt), 64'd2);

        // VERIFY restart on an off-window head.
        $display("[TB] verify restart");
        idle(10);
        sendHead();
        idle(4);
        checkOutput("verify_enter", 64'(bus.o_state), 64'd1);
        headAt(50);
        applyStimulus(1'b0, 1'b0);
        checkOutput("restart_cnt",   64'(bus.o_fram_cnt), 64'd0);
        checkOutput("restart_fhd",   64'(bus.o_fram_hd),  64'd1);
        checkOutput("restart_state", 64'(bus.o_state),    64'd1);
        for (int k = 0; k < 3; k++) begin
            headAt(99);
            idle(6);
            if (k == 0) checkOutput("restart_still_verify", 64'(bus.o_state), 64'd1);
        end
        checkOutput("restart_lock", 64'(bus.o_lock), 64'd1);

        // Resync in the same cycle as an on-time head at cnt 97.
        $display("[TB] resync priority");
        waitCnt(93);
        applyStimulus(1'b1, 1'b0);
        applyStimulus(1'b1, 1'b0);
        applyStimulus(1'b0, 1'b0);
        applyStimulus(1'b0, 1'b0);
        applyStimulus(1'b0, 1'b1);
        checkOutput("resync_cnt",   64'(bus.o_fram_cnt), 64'd98);
        checkOutput("resync_state", 64'(bus.o_state),    64'd0);
        checkOutput("resync_lock",  64'(bus.o_lock),     64'd0);
        checkOutput("resync_err",   64'(bus.o_err_cnt),  64'd2);

        // Reacquire, then reset asynchronously mid-frame.
        $display("[TB] reset mid-frame");
        idle(5);
        for (int k = 0; k < 3; k++) begin
            sendHead();
            idle(96);
        end
        checkOutput("reacq_lock", 64'(bus.o_lock), 64'd1);
        waitCnt(40);
        checkOutput("pre_rst_cnt", 64'(bus.o_fram_cnt), 64'd40);
        #2 rst = 1'b1;
        #1;
        checkOutput("midrst_cnt",   64'(bus.o_fram_cnt), 64'd0);
        checkOutput("midrst_fhd",   64'(bus.o_fram_hd),  64'd0);
        checkOutput("midrst_state", 64'(bus.o_state),    64'd0);
        checkOutput("midrst_lock",  64'(bus.o_lock),     64'd0);
        checkOutput("midrst_err",   64'(bus.o_err_cnt),  64'd0);
        modelReset();
        @(negedge clk);
        rst = 1'b0;

        // Randomized head stream with jitter, drops, spurious heads, resyncs.
        $display("[TB] random stream");
        cd = 50;
        pl = 0;
        for (int i = 0; i < 4000; i++) begin
            cd--;
            if (cd <= 0) begin
                if ($urandom_range(0, 19) != 0) pl = int'($urandom_range(1, 3));
                cd = 97 + int'($urandom_range(0, 6));
            end
            if ($urandom_range(0, 399) == 0) pl = 1;
            rs_b = ($urandom_range(0, 599) == 0);
            hd_b = (pl > 0);
            if (pl > 0) pl--;
            applyStimulus(hd_b, rs_b);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
